// File: rtl/shift_load_ctrl.sv
// Serialises a parallel word into a DFF shift chain, then captures and returns the chain contents.
// Latency: done_valid WIDTH+1 edges after accept; start is refused while busy, done is held until done_ready.
module shift_load_ctrl #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             abort,
  output logic             sh_en,
  output logic             s1,
  input  logic [WIDTH-1:0] q_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shadow, shadow_n;
  logic             dir_q, dir_n;
  logic             sh_en_n, s1_n, done_valid_n;
  logic [WIDTH-1:0] dout_n;
  logic             accept;

  assign start_ready = (state == IDLE) & ~abort;
  assign accept      = start_valid & start_ready;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (abort && state != IDLE) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = SHIFT;
        SHIFT:   if (cnt == LAST) state_n = SETTLE;
        SETTLE:  state_n = DONE;
        DONE:    if (done_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // The shadow word shifts along with s1, so the next bit is always at a fixed position.
  always_comb begin
    cnt_n        = cnt;
    shadow_n     = shadow;
    dir_n        = dir_q;
    sh_en_n      = sh_en;
    s1_n         = s1;
    done_valid_n = done_valid;
    dout_n       = dout;
    if (abort && state != IDLE) begin
      cnt_n        = '0;
      sh_en_n      = 1'b0;
      s1_n         = 1'b0;
      done_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shadow_n = din;
            dir_n    = dir;
            cnt_n    = '0;
            sh_en_n  = 1'b1;
            s1_n     = dir ? din[0] : din[WIDTH-1];
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            cnt_n   = '0;
            sh_en_n = 1'b0;
            s1_n    = 1'b0;
          end else begin
            cnt_n    = cnt + CW'(1);
            s1_n     = dir_q ? shadow[1] : shadow[WIDTH-2];
            shadow_n = dir_q ? (shadow >> 1) : (shadow << 1);
          end
        end
        SETTLE: begin
          dout_n       = q_in;
          done_valid_n = 1'b1;
        end
        DONE: begin
          if (done_ready) done_valid_n = 1'b0;
        end
        default: begin
          cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      shadow     <= '0;
      dir_q      <= 1'b0;
      sh_en      <= 1'b0;
      s1         <= 1'b0;
      done_valid <= 1'b0;
      dout       <= '0;
    end else begin
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      dir_q      <= dir_n;
      sh_en      <= sh_en_n;
      s1         <= s1_n;
      done_valid <= done_valid_n;
      dout       <= dout_n;
    end
  end

endmodule
